// File: rtl/vend_controller.sv
// Multi-slot vending sequencer: credit, per-slot stock, dispense and change handshakes.
// All outputs registered; one-cycle decision latency from any strobe or ack.
module vend_controller #(
    parameter int NUM_SLOTS  = 4,
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_val,
    input  logic                 cancel,
    input  logic                 sel_valid,
    input  logic [1:0]           sel_id,
    input  logic                 restock_valid,
    input  logic [1:0]           restock_id,
    input  logic [STOCK_W-1:0]   restock_cnt,
    output logic                 disp_req,
    output logic [1:0]           disp_id,
    input  logic                 disp_ack,
    output logic                 chg_req,
    input  logic                 chg_ack,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_SLOTS-1:0] sold_out,
    output logic                 coin_reject,
    output logic                 busy
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    state_t             state;
    logic [TMO_W-1:0]   tmo;
    logic [STOCK_W-1:0] stock     [NUM_SLOTS];
    logic [STOCK_W-1:0] stock_nxt [NUM_SLOTS];

    logic [CREDIT_W:0] coin_sum;
    logic [STOCK_W:0]  restock_sum;
    logic              coin_ok;
    logic              sel_ok;

    assign coin_sum    = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, coin_val};
    assign coin_ok     = ((coin_val == 2'b01) || (coin_val == 2'b10)) && (coin_sum <= CREDIT_MAX);
    assign sel_ok      = sel_valid && (credit >= PRICE_C) && (stock[sel_id] != '0);
    assign restock_sum = {1'b0, stock[restock_id]} + {1'b0, restock_cnt};

    // Stock only moves on a completed dispense or an IDLE restock (saturating).
    always_comb begin
        stock_nxt = stock;
        if (state == DISPENSE && disp_ack) begin
            stock_nxt[disp_id] = stock[disp_id] - STOCK_W'(1);
        end else if (state == IDLE && restock_valid) begin
            stock_nxt[restock_id] = restock_sum[STOCK_W] ? '1 : restock_sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            tmo         <= '0;
            disp_req    <= 1'b0;
            disp_id     <= 2'd0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            sold_out    <= {NUM_SLOTS{INIT_STOCK == 0}};
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            coin_reject <= 1'b0;
            stock       <= stock_nxt;
            for (int i = 0; i < NUM_SLOTS; i++) sold_out[i] <= (stock_nxt[i] == '0);

            case (state)
                IDLE: begin
                    if (coin_valid) begin
                        if (coin_ok) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            tmo    <= '0;
                            state  <= CREDIT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                // Priority: cancel, then an accepted selection, then coins, then timeout.
                CREDIT: begin
                    if (cancel) begin
                        coin_reject <= coin_valid;
                        chg_req     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CHANGE;
                    end else if (sel_ok) begin
                        coin_reject <= coin_valid;
                        disp_req    <= 1'b1;
                        disp_id     <= sel_id;
                        busy        <= 1'b1;
                        state       <= DISPENSE;
                    end else if (coin_valid) begin
                        tmo <= '0;
                        if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
                        else         coin_reject <= 1'b1;
                    end else if (sel_valid) begin
                        tmo <= '0;
                    end else if (tmo == TMO_LAST) begin
                        chg_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CHANGE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end

                DISPENSE: begin
                    coin_reject <= coin_valid;
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        credit   <= credit - PRICE_C;
                        if (credit != PRICE_C) begin
                            chg_req <= 1'b1;
                            state   <= CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (chg_ack) begin
                        credit <= credit - CREDIT_W'(1);
                        if (credit == CREDIT_W'(1)) begin
                            chg_req <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: expected handshake events queued by stimulus, popped by a monitor.
module tb_vend_controller;

    localparam int NUM_SLOTS  = 4;
    localparam int PRICE      = 3;
    localparam int CREDIT_W   = 4;
    localparam int STOCK_W    = 4;
    localparam int INIT_STOCK = 8;
    localparam int TIMEOUT    = 1000;

    localparam int EV_REJ  = 0;
    localparam int EV_DISP = 1;
    localparam int EV_CHG  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 coin_valid;
    logic [1:0]           coin_val;
    logic                 cancel;
    logic                 sel_valid;
    logic [1:0]           sel_id;
    logic                 restock_valid;
    logic [1:0]           restock_id;
    logic [STOCK_W-1:0]   restock_cnt;
    logic                 disp_req;
    logic [1:0]           disp_id;
    logic                 disp_ack;
    logic                 chg_req;
    logic                 chg_ack;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_SLOTS-1:0] sold_out;
    logic                 coin_reject;
    logic                 busy;

    vend_controller #(
        .NUM_SLOTS(NUM_SLOTS), .PRICE(PRICE), .CREDIT_W(CREDIT_W),
        .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel),
        .sel_valid(sel_valid), .sel_id(sel_id),
        .restock_valid(restock_valid), .restock_id(restock_id), .restock_cnt(restock_cnt),
        .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_ack(chg_ack),
        .credit(credit), .sold_out(sold_out),
        .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    function automatic void expect_ev(int kind, int a, int b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(int kind, int a, int b);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got kind=%0d a=%0d b=%0d, required no event", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                miscompares++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d, required kind=%0d a=%0d b=%0d",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endfunction

    // Monitor: reject pulses per high cycle; dispense reported at disp_req fall with
    // (slot, cycles high); change reported at chg_req fall with (acks seen, credit left).
    int disp_len  = 0;
    int disp_slot = 0;
    int chg_acks  = 0;
    bit chg_on    = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            disp_len = 0;
            chg_acks = 0;
            chg_on   = 1'b0;
        end else begin
            if (coin_reject) observe(EV_REJ, 0, 0);
            if (disp_req) begin
                if (disp_len == 0)                 disp_slot = int'(disp_id);
                else if (int'(disp_id) != disp_slot) disp_slot = -1;
                disp_len++;
            end else if (disp_len > 0) begin
                observe(EV_DISP, disp_slot, disp_len);
                disp_len = 0;
            end
            if (chg_req) begin
                chg_on = 1'b1;
                if (chg_ack) chg_acks++;
            end else if (chg_on) begin
                observe(EV_CHG, chg_acks, int'(credit));
                chg_on   = 1'b0;
                chg_acks = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        tick(1);
        coin_valid = 1'b0;
        coin_val   = 2'b00;
    endtask

    task automatic sel(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick(1);
        sel_valid = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
    endtask

    // Ack on the w-th cycle of disp_req, so disp_req is high for w cycles.
    task automatic dispense_ack(input int w);
        if (w > 1) tick(w - 1);
        disp_ack = 1'b1;
        tick(1);
        disp_ack = 1'b0;
    endtask

    task automatic refund(input int n);
        for (int i = 0; i < n; i++) begin
            chg_ack = 1'b1;
            tick(1);
            chg_ack = 1'b0;
            tick(1);
        end
    endtask

    task automatic do_restock(input logic [1:0] id, input logic [STOCK_W-1:0] cnt);
        restock_valid = 1'b1;
        restock_id    = id;
        restock_cnt   = cnt;
        tick(1);
        restock_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_credit", 32'(credit), 0);
        check("rst_disp_req", 32'(disp_req), 0);
        check("rst_chg_req", 32'(chg_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sold_out", 32'(sold_out), 0);
        for (int i = 0; i < NUM_SLOTS; i++) check("rst_stock", 32'(dut.stock[i]), INIT_STOCK);
    endtask

    initial begin
        rst = 1'b1;
        coin_valid = 1'b0; coin_val = 2'b00; cancel = 1'b0;
        sel_valid = 1'b0; sel_id = 2'd0;
        restock_valid = 1'b0; restock_id = 2'd0; restock_cnt = '0;
        disp_ack = 1'b0; chg_ack = 1'b0;
        tick(3);
        rst = 1'b0;
        check_reset_state();
        check("rst_coin_reject", 32'(coin_reject), 0);
        check("rst_disp_id", 32'(disp_id), 0);

        // Exact price: dispense slot 2, disp_req high 5 cycles, no change
        expect_ev(EV_DISP, 2, 5);
        coin(2'b01);
        coin(2'b10);
        check("credit_3", 32'(credit), 3);
        sel(2'd2);
        check("disp_id_2", 32'(disp_id), 2);
        dispense_ack(5);
        check("t1_credit", 32'(credit), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_chg_req", 32'(chg_req), 0);
        check("t1_stock2", 32'(dut.stock[2]), 7);

        // Over-pay by one, coin during DISPENSE rejected, one unit of change
        expect_ev(EV_REJ, 0, 0);
        expect_ev(EV_DISP, 0, 2);
        expect_ev(EV_CHG, 1, 0);
        coin(2'b10);
        coin(2'b10);
        sel(2'd0);
        coin(2'b01);
        check("t2_credit_hold", 32'(credit), 4);
        dispense_ack(1);
        check("t2_credit", 32'(credit), 1);
        check("t2_chg_req", 32'(chg_req), 1);
        check("t2_busy", 32'(busy), 1);
        refund(1);
        check("t2_credit_end", 32'(credit), 0);
        check("t2_busy_end", 32'(busy), 0);
        check("t2_stock0", 32'(dut.stock[0]), 7);

        // Insufficient credit, invalid coin code
        coin(2'b01);
        sel(2'd0);
        check("t3_no_disp", 32'(disp_req), 0);
        check("t3_credit", 32'(credit), 1);
        expect_ev(EV_REJ, 0, 0);
        coin(2'b11);
        check("t3_credit_inv", 32'(credit), 1);
        expect_ev(EV_CHG, 1, 0);
        pulse_cancel();
        refund(1);

        // Overflow: 8th two-unit coin rejected at credit 14
        expect_ev(EV_REJ, 0, 0);
        for (int i = 0; i < 8; i++) coin(2'b10);
        check("t3_credit_max", 32'(credit), 14);

        // Drain slot 1 to empty (8 dispenses total)
        expect_ev(EV_DISP, 1, 2);
        expect_ev(EV_CHG, 11, 0);
        sel(2'd1);
        dispense_ack(2);
        refund(11);
        for (int i = 0; i < 7; i++) begin
            expect_ev(EV_DISP, 1, 1 + (i % 3));
            coin(2'b10);
            coin(2'b01);
            sel(2'd1);
            dispense_ack(1 + (i % 3));
        end
        tick(1);
        check("t4_stock1", 32'(dut.stock[1]), 0);
        check("t4_sold_out", 32'(sold_out), 32'h2);
        coin(2'b10);
        coin(2'b01);
        sel(2'd1);
        check("t4_sold_sel", 32'(disp_req), 0);
        check("t4_sold_busy", 32'(busy), 0);
        check("t4_sold_credit", 32'(credit), 3);
        expect_ev(EV_CHG, 3, 0);
        pulse_cancel();
        refund(3);

        // Restock in IDLE, saturating at 15
        do_restock(2'd1, 4'd15);
        do_restock(2'd3, 4'd15);
        tick(1);
        check("t4_stock1_rs", 32'(dut.stock[1]), 15);
        check("t4_stock3_sat", 32'(dut.stock[3]), 15);
        check("t4_sold_out_rs", 32'(sold_out), 0);

        // Inactivity timeout refund
        coin(2'b10);
        tick(TIMEOUT - 1);
        check("t5_pre_tmo_busy", 32'(busy), 0);
        tick(1);
        check("t5_tmo_busy", 32'(busy), 1);
        check("t5_tmo_chg_req", 32'(chg_req), 1);
        check("t5_tmo_credit", 32'(credit), 2);
        expect_ev(EV_CHG, 2, 0);
        refund(2);
        check("t5_credit_end", 32'(credit), 0);
        check("t5_busy_end", 32'(busy), 0);

        // Cancel beats selection and coin in the same cycle
        coin(2'b10);
        coin(2'b01);
        expect_ev(EV_REJ, 0, 0);
        expect_ev(EV_CHG, 3, 0);
        cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; coin_valid = 1'b1; coin_val = 2'b01;
        tick(1);
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = 2'b00;
        check("t5_cancel_disp", 32'(disp_req), 0);
        check("t5_cancel_chg", 32'(chg_req), 1);
        check("t5_cancel_credit", 32'(credit), 3);
        refund(3);

        // Reset mid-DISPENSE
        coin(2'b10);
        coin(2'b01);
        sel(2'd2);
        tick(2);
        check("t6_in_disp", 32'(disp_req), 1);
        pulse_rst();
        check_reset_state();

        // Reset mid-CHANGE
        coin(2'b10);
        coin(2'b10);
        pulse_cancel();
        chg_ack = 1'b1;
        tick(1);
        chg_ack = 1'b0;
        check("t6_in_chg", 32'(credit), 3);
        pulse_rst();
        check_reset_state();

        tick(5);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got none required kind=%0d a=%0d b=%0d", e.kind, e.a, e.b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
